// File: rtl/sign_extend_pkg.sv
// rtl/sign_extend_pkg.sv - fill-mode constants and the sample extension function
package sign_extend_pkg;

    localparam logic [1:0] MODE_ZERO  = 2'b00;
    localparam logic [1:0] MODE_SIGN  = 2'b01;
    localparam logic [1:0] MODE_ONES  = 2'b10;
    localparam logic [1:0] MODE_ALIGN = 2'b11;

    // Widest output the extend() helper supports; callers pad into this width.
    localparam int EXT_MAX_W = 64;
    localparam logic [EXT_MAX_W-1:0] ONE_W = 1;

    // Width-generic extension: in_w/out_w are elaboration constants at every call site,
    // so the masks and shifts below fold to wiring.
    function automatic logic [EXT_MAX_W-1:0] extend(
        input logic [EXT_MAX_W-1:0] data,
        input logic [1:0]           mode,
        input int                   in_w,
        input int                   out_w
    );
        logic [EXT_MAX_W-1:0] in_mask;
        logic [EXT_MAX_W-1:0] out_mask;
        logic [EXT_MAX_W-1:0] fill;
        logic [EXT_MAX_W-1:0] sample;
        logic [EXT_MAX_W-1:0] result;
        logic                 sign;

        in_mask  = (ONE_W << in_w) - ONE_W;
        out_mask = (out_w >= EXT_MAX_W) ? '1 : ((ONE_W << out_w) - ONE_W);
        sample   = data & in_mask;
        fill     = out_mask & ~in_mask;
        sign     = |(sample & (ONE_W << (in_w - 1)));

        case (mode)
            MODE_ZERO: result = sample;
            MODE_SIGN: result = sign ? (sample | fill) : sample;
            MODE_ONES: result = sample | fill;
            default:   result = (sample << (out_w - in_w)) & out_mask;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/sign_extend_stream_skid_buffer.sv
// rtl/sign_extend_stream_skid_buffer.sv - registered valid/ready stage with one skid entry
module skid_buffer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         s_valid,
    output logic         s_ready,
    input  logic [W-1:0] s_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data
);

    logic         or_valid;
    logic [W-1:0] or_data;
    logic         sr_valid;
    logic [W-1:0] sr_data;
    logic         acc;
    logic         pop;

    // s_ready comes straight from a flop so upstream never sees a path from m_ready.
    assign s_ready = ~sr_valid;
    assign m_valid = or_valid;
    assign m_data  = or_data;
    assign acc     = s_valid & ~sr_valid;
    assign pop     = or_valid & m_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_valid <= 1'b0;
            or_data  <= '0;
            sr_valid <= 1'b0;
            sr_data  <= '0;
        end else if (!or_valid || pop) begin
            if (sr_valid) begin
                // acc is impossible here because s_ready was low.
                or_valid <= 1'b1;
                or_data  <= sr_data;
                sr_valid <= 1'b0;
            end else begin
                or_valid <= acc;
                if (acc) begin
                    or_data <= s_data;
                end
            end
        end else if (acc) begin
            sr_valid <= 1'b1;
            sr_data  <= s_data;
        end
    end

endmodule

// File: rtl/sign_extend_stream.sv
// rtl/sign_extend_stream.sv - widens narrow samples per-beat fill mode, skid-buffered, beat counter
module sign_extend_stream
    import sign_extend_pkg::*;
#(
    parameter int IN_W  = 8,
    parameter int OUT_W = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [IN_W-1:0]  s_data,
    input  logic [1:0]       s_mode,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [OUT_W-1:0] m_data,
    output logic [CNT_W-1:0] beat_cnt
);

    if (OUT_W <= IN_W) begin : g_bad_width
        $error("sign_extend_stream: OUT_W must be greater than IN_W");
    end
    if (OUT_W > EXT_MAX_W) begin : g_too_wide
        $error("sign_extend_stream: OUT_W exceeds extend() capacity");
    end

    logic [EXT_MAX_W-1:0] ext_wide;
    logic [OUT_W-1:0]     ext_data;
    logic                 unused_ext;

    // Extension happens before the buffer so stored beats already carry their final form.
    assign ext_wide   = extend(EXT_MAX_W'(s_data), s_mode, IN_W, OUT_W);
    assign ext_data   = ext_wide[OUT_W-1:0];
    assign unused_ext = ^ext_wide;

    skid_buffer #(
        .W(OUT_W)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (ext_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt <= '0;
        end else if (m_valid && m_ready) begin
            beat_cnt <= beat_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_sign_extend_stream.sv
// tb/tb_sign_extend_stream.sv - directed self-checking bench for sign_extend_stream
module tb_sign_extend_stream;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic        m_ready;
    logic [7:0]  s_data;
    logic [1:0]  s_mode;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic [15:0] beat_cnt;
    logic        s_ready4;
    logic        m_valid4;
    logic [31:0] m_data4;
    logic [3:0]  beat_cnt4;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    sign_extend_stream #(.IN_W(8), .OUT_W(32), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready),
        .s_data(s_data), .s_mode(s_mode), .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .beat_cnt(beat_cnt)
    );

    sign_extend_stream #(.IN_W(8), .OUT_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready4),
        .s_data(s_data), .s_mode(s_mode), .m_valid(m_valid4), .m_ready(m_ready),
        .m_data(m_data4), .beat_cnt(beat_cnt4)
    );

    function automatic logic [31:0] model_ext(input logic [7:0] d, input logic [1:0] mode);
        case (mode)
            2'd0:    return {24'h000000, d};
            2'd1:    return {{24{d[7]}}, d};
            2'd2:    return {24'hFFFFFF, d};
            default: return {d, 24'h000000};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;
        s_mode  = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b0;
        s_data  = 8'h00;
        s_mode  = 2'b00;
        tick();
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || m_data !== 32'h0 || beat_cnt !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_state: m_valid=%b s_ready=%b m_data=%h beat_cnt=%0d, expected 0/1/00000000/0",
                     m_valid, s_ready, m_data, beat_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic_modes();
        logic [31:0] exp_v [4];
        exp_v[0] = 32'h00000080;
        exp_v[1] = 32'hFFFFFF80;
        exp_v[2] = 32'hFFFFFF80;
        exp_v[3] = 32'h80000000;
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h80;
        for (int i = 0; i < 4; i++) begin
            s_mode = 2'(i);
            tick();
            vectors++;
            if (m_valid !== 1'b1 || m_data !== exp_v[i] || s_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL mode_%0d: m_valid=%b m_data=%h s_ready=%b, expected 1/%h/1",
                         i, m_valid, m_data, s_ready, exp_v[i]);
            end
        end
        s_valid = 1'b0;
        tick();
        vectors++;
        if (m_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL modes_drain: m_valid=%b, expected 0", m_valid);
        end
    endtask

    task automatic test_extend_values();
        logic [7:0]  din [4];
        logic [1:0]  mod [4];
        logic [31:0] exp_v [4];
        din[0] = 8'h7F; mod[0] = 2'b01; exp_v[0] = 32'h0000007F;
        din[1] = 8'hFF; mod[1] = 2'b00; exp_v[1] = 32'h000000FF;
        din[2] = 8'h00; mod[2] = 2'b10; exp_v[2] = 32'hFFFFFF00;
        din[3] = 8'h01; mod[3] = 2'b11; exp_v[3] = 32'h01000000;
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_data = din[i];
            s_mode = mod[i];
            tick();
            vectors++;
            if (m_valid !== 1'b1 || m_data !== exp_v[i]) begin
                miscompares++;
                $display("FAIL extend_%0d: m_valid=%b m_data=%h, expected 1/%h", i, m_valid, m_data, exp_v[i]);
            end
        end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_mode  = 2'b00;
        s_data  = 8'h01;
        tick();
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h1 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_first: m_valid=%b m_data=%h s_ready=%b, expected 1/00000001/1", m_valid, m_data, s_ready);
        end
        s_data = 8'h02;
        tick();
        vectors++;
        if (s_ready !== 1'b0 || m_data !== 32'h1) begin
            miscompares++;
            $display("FAIL bp_full: s_ready=%b m_data=%h, expected 0/00000001", s_ready, m_data);
        end
        s_data = 8'h03;
        tick();
        vectors++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h1) begin
            miscompares++;
            $display("FAIL bp_hold: s_ready=%b m_valid=%b m_data=%h, expected 0/1/00000001", s_ready, m_valid, m_data);
        end
        m_ready = 1'b1;
        tick();
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h2 || s_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_second: m_valid=%b m_data=%h s_ready=%b, expected 1/00000002/1", m_valid, m_data, s_ready);
        end
        tick();
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'h3) begin
            miscompares++;
            $display("FAIL bp_third: m_valid=%b m_data=%h, expected 1/00000003", m_valid, m_data);
        end
        s_valid = 1'b0;
        tick();
        vectors++;
        if (m_valid !== 1'b0 || beat_cnt !== 16'd3) begin
            miscompares++;
            $display("FAIL bp_drain: m_valid=%b beat_cnt=%0d, expected 0/3", m_valid, beat_cnt);
        end
    endtask

    task automatic test_random_stream();
        logic [31:0] q [$];
        logic [31:0] hold;
        logic [31:0] exp_v;
        logic        stall;
        int          sent = 0;
        int          got  = 0;
        int          cyc  = 0;
        do_reset();
        while (got < 100 && cyc < 2000) begin
            if (sent < 100) begin
                s_valid = 1'b1;
                s_data  = 8'($urandom);
                s_mode  = 2'($urandom_range(0, 3));
            end else begin
                s_valid = 1'b0;
            end
            m_ready = (cyc % 2 == 0);
            if (s_valid && s_ready) begin
                q.push_back(model_ext(s_data, s_mode));
                sent++;
            end
            stall = m_valid && !m_ready;
            hold  = m_data;
            if (m_valid && m_ready) begin
                vectors++;
                if (q.size() == 0) begin
                    miscompares++;
                    $display("FAIL stream_extra: m_data=%h, expected no beat", m_data);
                end else begin
                    exp_v = q.pop_front();
                    if (m_data !== exp_v) begin
                        miscompares++;
                        $display("FAIL stream_beat_%0d: m_data=%h, expected %h", got, m_data, exp_v);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            if (stall) begin
                vectors++;
                if (m_valid !== 1'b1 || m_data !== hold) begin
                    miscompares++;
                    $display("FAIL stream_stall: m_valid=%b m_data=%h, expected 1/%h", m_valid, m_data, hold);
                end
            end
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        vectors++;
        if (got !== 100 || sent !== 100) begin
            miscompares++;
            $display("FAIL stream_count: received=%0d sent=%0d, expected 100/100", got, sent);
        end
    endtask

    task automatic test_count_wrap();
        int pops = 0;
        int cyc  = 0;
        do_reset();
        s_valid = 1'b1;
        s_data  = 8'h11;
        s_mode  = 2'b00;
        while (pops < 17 && cyc < 200) begin
            m_ready = (cyc % 3 != 2);
            if (m_valid && m_ready) pops++;
            tick();
            cyc++;
        end
        s_valid = 1'b0;
        m_ready = 1'b0;
        vectors++;
        if (pops !== 17 || beat_cnt4 !== 4'd1 || beat_cnt !== 16'd17) begin
            miscompares++;
            $display("FAIL count_wrap: pops=%0d beat_cnt4=%0d beat_cnt=%0d, expected 17/1/17", pops, beat_cnt4, beat_cnt);
        end
        repeat (3) tick();
        vectors++;
        if (beat_cnt4 !== 4'd1 || beat_cnt !== 16'd17) begin
            miscompares++;
            $display("FAIL count_stalled: beat_cnt4=%0d beat_cnt=%0d, expected 1/17", beat_cnt4, beat_cnt);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h05;
        s_mode  = 2'b00;
        tick();
        s_valid = 1'b0;
        tick();
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h06;
        tick();
        s_data = 8'h07;
        tick();
        s_valid = 1'b0;
        vectors++;
        if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 32'h6 || beat_cnt !== 16'd1) begin
            miscompares++;
            $display("FAIL rst_setup: s_ready=%b m_valid=%b m_data=%h beat_cnt=%0d, expected 0/1/00000006/1",
                     s_ready, m_valid, m_data, beat_cnt);
        end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (m_valid !== 1'b0 || s_ready !== 1'b1 || beat_cnt !== 16'd0 || m_data !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_async: m_valid=%b s_ready=%b beat_cnt=%0d m_data=%h, expected 0/1/0/00000000",
                     m_valid, s_ready, beat_cnt, m_data);
        end
        @(negedge clk);
        rst_n   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'h81;
        s_mode  = 2'b01;
        tick();
        s_valid = 1'b0;
        vectors++;
        if (m_valid !== 1'b1 || m_data !== 32'hFFFFFF81) begin
            miscompares++;
            $display("FAIL rst_first_beat: m_valid=%b m_data=%h, expected 1/FFFFFF81", m_valid, m_data);
        end
    endtask

    initial begin
        test_reset();
        test_basic_modes();
        test_extend_values();
        test_backpressure();
        test_random_stream();
        test_count_wrap();
        test_reset_mid_stream();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
